gate_selftest_ctrl: RTL and testbench

Self-test sequencer for the two-input gate unit (inputs A, B; outputs C, D, E).
- Drives the four input combinations in order {B,A} = 00, 01, 10, 11.
- Waits a programmable settle time after each vector, then compares C/D/E against per-output truth tables.
- Reports pass/fail, a mismatch mask, a mismatch count and the first failing vector.
- Sits between the lab top-level (start button/LEDs) and the gate unit instance.

---
 rtl/gate_test_pkg.sv | 18 +
 rtl/gate_selftest_ctrl_settle_timer.sv | 29 ++
 rtl/gate_selftest_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gate_selftest_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate unit self-test sequencer.
package gate_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int VEC_COUNT = 4;

   // Truth tables indexed by {B,A}
   localparam logic [3:0] EXP_AND = 4'b1000;
   localparam logic [3:0] EXP_OR  = 4'b1110;
   localparam logic [3:0] EXP_XOR = 4'b0110;

endpackage

// File: rtl/gate_selftest_ctrl_settle_timer.sv
// Per-vector settle counter: cleared on vector entry, counts while enabled,
// flags expiry on the last settle cycle.
module settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [7:0] LP_LAST = 8'(SETTLE_CYCLES - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_enable) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_expired = (r_count == LP_LAST);

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for the two-input gate unit: walks {B,A}=00..11, checks C/D/E.
// Result is ready 4*(SETTLE_CYCLES+1) cycles after start; start is ignored while busy.
module gate_selftest_ctrl
   import gate_test_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [3:0] EXP_C         = EXP_AND,
   parameter logic [3:0] EXP_D         = EXP_OR,
   parameter logic [3:0] EXP_E         = EXP_XOR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       c_in,
   input  logic       d_in,
   input  logic       e_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_mask,
   output logic [3:0] err_count,
   output logic [1:0] first_fail_idx,
   output logic       first_fail_vld
);

   function automatic logic [1:0] popcnt3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   state_t     r_state;
   logic [1:0] r_idx;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [2:0] r_mask;
   logic [3:0] r_cnt;
   logic [1:0] r_ffi;
   logic       r_ffv;

   state_t     w_state;
   logic [1:0] w_idx;
   logic       w_busy;
   logic       w_done;
   logic       w_pass;
   logic [2:0] w_mask;
   logic [3:0] w_cnt;
   logic [1:0] w_ffi;
   logic       w_ffv;
   logic       w_tmr_clear;
   logic       w_expired;
   logic [2:0] w_mism;
   logic [4:0] w_sum;
   logic [3:0] w_cnt_sum;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_tmr_clear),
      .i_enable (r_state == SETTLE),
      .o_expired(w_expired)
   );

   // The vector index is the registered A/B drive itself, so it is only meaningful in CHECK
   assign w_mism    = {e_in ^ EXP_E[r_idx], d_in ^ EXP_D[r_idx], c_in ^ EXP_C[r_idx]};
   assign w_sum     = {1'b0, r_cnt} + {3'b000, popcnt3(w_mism)};
   assign w_cnt_sum = (w_sum > 5'd15) ? 4'hF : w_sum[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= 2'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_mask  <= 3'd0;
         r_cnt   <= 4'd0;
         r_ffi   <= 2'd0;
         r_ffv   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_mask  <= w_mask;
         r_cnt   <= w_cnt;
         r_ffi   <= w_ffi;
         r_ffv   <= w_ffv;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_busy      = r_busy;
      w_done      = r_done;
      w_pass      = r_pass;
      w_mask      = r_mask;
      w_cnt       = r_cnt;
      w_ffi       = r_ffi;
      w_ffv       = r_ffv;
      w_tmr_clear = 1'b0;

      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_idx       = 2'd0;
               w_mask      = 3'd0;
               w_cnt       = 4'd0;
               w_ffi       = 2'd0;
               w_ffv       = 1'b0;
               w_done      = 1'b0;
               w_pass      = 1'b0;
               w_busy      = 1'b1;
               w_tmr_clear = 1'b1;
               w_state     = SETTLE;
            end
         end
         SETTLE: begin
            if (w_expired) begin
               w_state = CHECK;
            end
         end
         CHECK: begin
            w_mask = r_mask | w_mism;
            w_cnt  = w_cnt_sum;
            if ((w_mism != 3'd0) && !r_ffv) begin
               w_ffi = r_idx;
               w_ffv = 1'b1;
            end
            if (r_idx == 2'(VEC_COUNT - 1)) begin
               w_state = DONE;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_pass  = (w_mask == 3'd0);
            end else begin
               w_idx       = r_idx + 2'd1;
               w_tmr_clear = 1'b1;
               w_state     = SETTLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      // Abort beats everything, including a coincident start
      if (abort) begin
         w_state     = IDLE;
         w_idx       = 2'd0;
         w_busy      = 1'b0;
         w_done      = 1'b0;
         w_pass      = 1'b0;
         w_mask      = 3'd0;
         w_cnt       = 4'd0;
         w_ffi       = 2'd0;
         w_ffv       = 1'b0;
         w_tmr_clear = 1'b1;
      end
   end

   assign a_out          = r_idx[0];
   assign b_out          = r_idx[1];
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_mask       = r_mask;
   assign err_count      = r_cnt;
   assign first_fail_idx = r_ffi;
   assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: two instances (settle 2 and 1) driven by a faultable gate model.
module tb_gate_selftest_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]      st, ab, a_o, b_o, busy_o, done_o, pass_o, ffv_o, c_i, d_i, e_i;
   logic [1:0][2:0] mask_o;
   logic [1:0][3:0] cnt_o;
   logic [1:0][1:0] ffi_o;

   int         fc_c, fc_d, fc_e;
   logic [2:0] noise;
   int         errors = 0;
   int         checks = 0;

   // Fault codes: 0 healthy, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
   function automatic logic apply_fault(input int code, input logic good);
      case (code)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return ~good;
         default: return good;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_gate
      assign c_i[g] = apply_fault(fc_c, a_o[g] & b_o[g]) ^ noise[0];
      assign d_i[g] = apply_fault(fc_d, a_o[g] | b_o[g]) ^ noise[1];
      assign e_i[g] = apply_fault(fc_e, a_o[g] ^ b_o[g]) ^ noise[2];
   end

   gate_selftest_ctrl #(.SETTLE_CYCLES(2)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
      .c_in(c_i[0]), .d_in(d_i[0]), .e_in(e_i[0]),
      .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .err_mask(mask_o[0]), .err_count(cnt_o[0]),
      .first_fail_idx(ffi_o[0]), .first_fail_vld(ffv_o[0])
   );

   gate_selftest_ctrl #(.SETTLE_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
      .c_in(c_i[1]), .d_in(d_i[1]), .e_in(e_i[1]),
      .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .err_mask(mask_o[1]), .err_count(cnt_o[1]),
      .first_fail_idx(ffi_o[1]), .first_fail_vld(ffv_o[1])
   );

   // Status word: {b,a,busy,done,pass,err_mask[2:0],err_count[3:0],ffv,ffi[1:0]}
   function automatic logic [14:0] obs(input int s);
      return {b_o[s], a_o[s], busy_o[s], done_o[s], pass_o[s],
              mask_o[s], cnt_o[s], ffv_o[s], ffi_o[s]};
   endfunction

   // Mismatch bits {E,D,C} the current fault set produces for vector v={B,A}
   function automatic logic [2:0] mism_of(input int v);
      logic a, b;
      a = v[0];
      b = v[1];
      return {apply_fault(fc_e, a ^ b) != (a ^ b),
              apply_fault(fc_d, a | b) != (a | b),
              apply_fault(fc_c, a & b) != (a & b)};
   endfunction

   // Expected status t cycles after the start-sampling edge, period P per vector
   function automatic logic [14:0] exp_at(input int t, input int p, input logic [3:0][2:0] m);
      int         k;
      logic [2:0] mask;
      logic [3:0] cnt;
      logic       ffv, busy_e, done_e;
      logic [1:0] ffi, vec;
      k    = (t / p > 4) ? 4 : t / p;
      mask = '0;
      cnt  = '0;
      ffv  = 1'b0;
      ffi  = '0;
      for (int v = 0; v < k; v++) begin
         mask = mask | m[v];
         cnt  = cnt + 4'($countones(m[v]));
         if (m[v] != 3'd0 && !ffv) begin
            ffv = 1'b1;
            ffi = 2'(v);
         end
      end
      busy_e = (t < 4 * p);
      done_e = !busy_e;
      vec    = busy_e ? 2'(t / p) : 2'd3;
      return {vec[1], vec[0], busy_e, done_e, done_e && (mask == 3'd0), mask, cnt, ffv, ffi};
   endfunction

   task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   // One run on instance s; optional ignored mid-run start, SETTLE-time noise, abort edge
   task automatic run(input int s, input bit mid_start, input bit noisy, input int abort_at);
      int               p, last;
      logic [3:0][2:0]  m;
      logic [14:0]      e;
      p    = (s == 0) ? 3 : 2;
      last = 4 * p;
      for (int v = 0; v < 4; v++) m[v] = mism_of(v);
      st[s] = 1'b1;
      @(posedge clk); #1;
      st[s] = 1'b0;
      for (int t = 0; t <= last; t++) begin
         e = (abort_at >= 0 && t >= abort_at) ? 15'd0 : exp_at(t, p, m);
         chk($sformatf("u%0d_t%0d_f%0d%0d%0d", s, t, fc_c, fc_d, fc_e), obs(s), e);
         if (abort_at >= 0 && t >= abort_at + 3) break;
         noise = (noisy && (t % p) != p - 1) ? 3'($urandom) : 3'd0;
         st[s] = (mid_start && t == 4) || (abort_at >= 0 && t == abort_at - 1);
         ab[s] = (abort_at >= 0 && t == abort_at - 1);
         @(posedge clk); #1;
      end
      noise = 3'd0;
      st[s] = 1'b0;
      ab[s] = 1'b0;
   endtask

   initial begin
      st = '0; ab = '0; noise = '0;
      fc_c = 0; fc_d = 0; fc_e = 0;
      #2;
      chk("reset_u0", obs(0), 15'd0);
      chk("reset_u1", obs(1), 15'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run(0, 1'b0, 1'b0, -1);                 // healthy gate
      fc_c = 1; run(0, 1'b0, 1'b0, -1);       // C stuck-at-0
      fc_c = 0; fc_e = 3; run(0, 1'b0, 1'b0, -1);   // E inverted
      fc_e = 0;
      run(0, 1'b1, 1'b0, -1);                 // re-start mid-run ignored
      run(0, 1'b0, 1'b0, -1);                 // restart from DONE
      run(0, 1'b0, 1'b0, 7);                  // abort+start at edge 7

      // Async reset in the middle of vector 2
      st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      repeat (7) @(posedge clk);
      #4 rst = 1'b1;
      #1;
      chk("rst_async_u0", obs(0), 15'd0);
      chk("rst_async_u1", obs(1), 15'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_after_u0", obs(0), 15'd0);

      run(1, 1'b0, 1'b0, -1);                 // settle=1, done at edge 8

      for (int i = 0; i < 20; i++) begin
         fc_c = int'($urandom_range(0, 3));
         fc_d = int'($urandom_range(0, 3));
         fc_e = int'($urandom_range(0, 3));
         run(i % 4 == 3 ? 1 : 0, 1'(i % 3 == 1), 1'b1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
